// File: rtl/io_bus_pkg.sv
// Shared types and constants for the IO bus master: op codes, FSM states,
// default widths and the IO address map.
package io_bus_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_IRQ_W  = 8;

  localparam logic [DEF_ADDR_W-1:0] IO_ADDR_SWKEY = 5'd0;
  localparam logic [DEF_ADDR_W-1:0] IO_ADDR_LED   = 5'd1;
  localparam logic [DEF_ADDR_W-1:0] IO_ADDR_TIMER = 5'd2;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_BSET  = 2'd2,
    OP_BCLR  = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RADDR = 3'd1,
    RDATA = 3'd2,
    WRITE = 3'd3,
    RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/io_irq_latch.sv
// Interrupt collector: pending flag plus lowest-index priority encoder.
// IO_IRQ_LATCH_EN selects rising-edge latched pending bits cleared by irq_ack.
module io_irq_latch #(
  parameter int IRQ_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IRQ_W-1:0] io_interrupts,
  input  logic             irq_ack,
  output logic             irq_valid,
  output logic [2:0]       irq_id
);

  logic [IRQ_W-1:0] w_src;

`ifdef IO_IRQ_LATCH_EN
  logic [IRQ_W-1:0] r_prev;
  logic [IRQ_W-1:0] r_pending;
  logic [IRQ_W-1:0] w_clr;

  always_comb begin
    w_clr = '0;
    if (irq_ack) w_clr[irq_id] = 1'b1;
  end

  // A new rising edge overrides an acknowledge of the same line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev    <= '0;
      r_pending <= '0;
    end else begin
      r_prev    <= io_interrupts;
      r_pending <= (r_pending & ~w_clr) | (io_interrupts & ~r_prev);
    end
  end

  assign w_src = r_pending;
`else
  logic w_unused;
  assign w_unused = ^{clk, irq_ack};
  assign w_src    = reset ? '0 : io_interrupts;
`endif

  always_comb begin
    irq_valid = |w_src;
    irq_id    = '0;
    for (int i = IRQ_W - 1; i >= 0; i--) begin
      if (w_src[i]) irq_id = 3'(i);
    end
  end

endmodule

// File: rtl/io_bus_master.sv
// CPU-side initiator for the IO bus (registered read address, 1-cycle read
// latency) with read/write/bit-set/bit-clear ops. Optional IO_IRQ_LATCH_EN in io_irq_latch.
module io_bus_master import io_bus_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int IRQ_W  = DEF_IRQ_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic [ADDR_W-1:0] io_readaddr,
  input  logic [DATA_W-1:0] io_readdata,
  output logic [ADDR_W-1:0] io_writeaddr,
  output logic [DATA_W-1:0] io_writedata,
  output logic              io_write_en,
  input  logic [IRQ_W-1:0]  io_interrupts,
  output logic              irq_valid,
  output logic [2:0]        irq_id,
  input  logic              irq_ack
);

  state_e            r_state, w_state_next;
  op_e               r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_resp_data;
  logic [ADDR_W-1:0] r_readaddr;
  logic [ADDR_W-1:0] r_writeaddr;
  logic [DATA_W-1:0] r_writedata;
  logic              w_handshake;
  op_e               w_req_op;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_modify;

  assign w_req_op    = op_e'(req_op);
  assign req_ready   = (r_state == IDLE) && !reset;
  assign w_handshake = req_valid && req_ready;
  assign w_mask      = {{(DATA_W-1){1'b0}}, 1'b1} << r_wdata[2:0];
  assign w_modify    = (r_op == OP_BSET) ? (io_readdata | w_mask) : (io_readdata & ~w_mask);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_handshake) w_state_next = (w_req_op == OP_WRITE) ? WRITE : RADDR;
      RADDR:   w_state_next = RDATA;
      RDATA:   w_state_next = (r_op == OP_READ) ? RESP : WRITE;
      WRITE:   w_state_next = RESP;
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // The read address is launched at the handshake so it is on the bus during
  // RADDR and the responder's data is ready to capture in RDATA.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_resp_data <= '0;
      r_readaddr  <= '0;
      r_writeaddr <= '0;
      r_writedata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_handshake) begin
        r_op    <= w_req_op;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        if (w_req_op == OP_WRITE) begin
          r_writeaddr <= req_addr;
          r_writedata <= req_wdata;
        end else begin
          r_readaddr <= req_addr;
        end
      end
      if (r_state == RDATA) begin
        r_resp_data <= io_readdata;
        if (r_op != OP_READ) begin
          r_writeaddr <= r_addr;
          r_writedata <= w_modify;
        end
      end
      if (r_state == WRITE && r_op == OP_WRITE) r_resp_data <= r_wdata;
    end
  end

  assign io_write_en  = (r_state == WRITE);
  assign resp_valid   = (r_state == RESP);
  assign resp_data    = r_resp_data;
  assign io_readaddr  = r_readaddr;
  assign io_writeaddr = r_writeaddr;
  assign io_writedata = r_writedata;

  io_irq_latch #(.IRQ_W(IRQ_W)) u_irq (
    .clk           (clk),
    .reset         (reset),
    .io_interrupts (io_interrupts),
    .irq_ack       (irq_ack),
    .irq_valid     (irq_valid),
    .irq_id        (irq_id)
  );

endmodule

// File: tb/tb_io_bus_master.sv
// Table-driven bench for io_bus_master with a registered-read-address responder
// model, plus sequences for back-to-back requests, mid-op reset and interrupts.
module tb_io_bus_master;
  import io_bus_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_op = 2'd0;
  logic [4:0] req_addr = 5'd0;
  logic [7:0] req_wdata = 8'd0;
  logic       resp_valid;
  logic [7:0] resp_data;
  logic [4:0] io_readaddr;
  logic [7:0] io_readdata;
  logic [4:0] io_writeaddr;
  logic [7:0] io_writedata;
  logic       io_write_en;
  logic [7:0] io_interrupts = 8'd0;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       irq_ack = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_bus_master dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .resp_valid    (resp_valid),
    .resp_data     (resp_data),
    .io_readaddr   (io_readaddr),
    .io_readdata   (io_readdata),
    .io_writeaddr  (io_writeaddr),
    .io_writedata  (io_writedata),
    .io_write_en   (io_write_en),
    .io_interrupts (io_interrupts),
    .irq_valid     (irq_valid),
    .irq_id        (irq_id),
    .irq_ack       (irq_ack)
  );

  // Responder: registered read address, write on the strobe edge.
  logic [7:0] mem [32] = '{1: 8'h05, default: 8'h00};
  logic [4:0] resp_raddr = 5'd0;
  always @(posedge clk) begin
    resp_raddr <= io_readaddr;
    if (io_write_en) mem[io_writeaddr] <= io_writedata;
  end
  assign io_readdata = mem[resp_raddr];

  logic watch = 1'b0;
  logic saw_wr = 1'b0;
  always @(negedge clk) if (watch && io_write_en) saw_wr = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge after RESP.
  task automatic run_op(input logic [1:0] op, input logic [4:0] addr, input logic [7:0] wd,
                        output int lat, output int nwr, output logic [7:0] wval,
                        output logic [4:0] waddr, output logic [4:0] raddr1,
                        output logic [7:0] rdata);
    lat = 0; nwr = 0; wval = 8'h00; waddr = 5'd0; raddr1 = 5'd0; rdata = 8'h00;
    check("ready_before_req", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) raddr1 = io_readaddr;
      if (io_write_en) begin nwr++; wval = io_writedata; waddr = io_writeaddr; end
      if (resp_valid) begin lat = c; rdata = resp_data; break; end
    end
    if (lat != 0) @(negedge clk);
    $display("op=%0d addr=%0d wdata=%02h resp=%02h lat=%0d writes=%0d", op, addr, wd, rdata, lat, nwr);
  endtask

  typedef struct {
    logic [1:0] op;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_resp;
    int         exp_lat;
    int         exp_nwr;
    logic [7:0] exp_wval;
  } vec_t;

  vec_t vecs[10];

  logic [1:0] b_op   [5] = '{OP_WRITE, OP_READ, OP_BSET, OP_BCLR, OP_READ};
  logic [7:0] b_wd   [5] = '{8'h11, 8'h00, 8'h01, 8'h00, 8'h00};
  logic [7:0] b_resp [5] = '{8'h11, 8'h11, 8'h11, 8'h13, 8'h12};
  int         b_lat  [5] = '{2, 3, 4, 4, 3};

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nwr, k, busy, nresp, bwr, ready_bad;
    logic [7:0] wval, rdata;
    logic [4:0] waddr, raddr1;

    vecs[0] = '{OP_READ,  IO_ADDR_LED,   8'h00, 8'h05, 3, 0, 8'h00};
    vecs[1] = '{OP_WRITE, IO_ADDR_LED,   8'hA3, 8'hA3, 2, 1, 8'hA3};
    vecs[2] = '{OP_READ,  IO_ADDR_LED,   8'h00, 8'hA3, 3, 0, 8'h00};
    vecs[3] = '{OP_BSET,  IO_ADDR_LED,   8'h02, 8'hA3, 4, 1, 8'hA7};
    vecs[4] = '{OP_BCLR,  IO_ADDR_LED,   8'h07, 8'hA7, 4, 1, 8'h27};
    vecs[5] = '{OP_BSET,  IO_ADDR_TIMER, 8'hF8, 8'h00, 4, 1, 8'h01};
    vecs[6] = '{OP_READ,  IO_ADDR_TIMER, 8'h00, 8'h01, 3, 0, 8'h00};
    vecs[7] = '{OP_WRITE, IO_ADDR_SWKEY, 8'h5A, 8'h5A, 2, 1, 8'h5A};
    vecs[8] = '{OP_BCLR,  IO_ADDR_SWKEY, 8'h0C, 8'h5A, 4, 1, 8'h4A};
    vecs[9] = '{OP_READ,  IO_ADDR_LED,   8'h00, 8'h27, 3, 0, 8'h00};

    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_ready",      {31'd0, req_ready},   32'd0);
    check("rst_resp_valid", {31'd0, resp_valid},  32'd0);
    check("rst_resp_data",  {24'd0, resp_data},   32'd0);
    check("rst_write_en",   {31'd0, io_write_en}, 32'd0);
    check("rst_readaddr",   {27'd0, io_readaddr}, 32'd0);
    check("rst_writedata",  {24'd0, io_writedata}, 32'd0);
    check("rst_irq_valid",  {31'd0, irq_valid},   32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].addr, vecs[i].wdata, lat, nwr, wval, waddr, raddr1, rdata);
      check($sformatf("v%0d_resp", i), {24'd0, rdata}, {24'd0, vecs[i].exp_resp});
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_nwr", i), nwr, vecs[i].exp_nwr);
      if (vecs[i].exp_nwr > 0) begin
        check($sformatf("v%0d_wdata", i), {24'd0, wval}, {24'd0, vecs[i].exp_wval});
        check($sformatf("v%0d_waddr", i), {27'd0, waddr}, {27'd0, vecs[i].addr});
      end
      if (vecs[i].op != OP_WRITE)
        check($sformatf("v%0d_readaddr", i), {27'd0, raddr1}, {27'd0, vecs[i].addr});
    end

    // Back-to-back: request held valid continuously across five ops.
    k = 0; busy = 0; nresp = 0; bwr = 0; ready_bad = 0;
    for (int cyc = 0; cyc < 60 && (k < 5 || busy > 0 || nresp < 5); cyc++) begin
      if (k < 5) begin
        req_valid = 1'b1; req_op = b_op[k]; req_addr = 5'd3; req_wdata = b_wd[k];
      end else begin
        req_valid = 1'b0;
      end
      #1;
      if (req_ready !== (busy == 0)) ready_bad++;
      if (io_write_en) bwr++;
      if (resp_valid) begin
        if (nresp < 5) check($sformatf("b2b_resp%0d", nresp), {24'd0, resp_data}, {24'd0, b_resp[nresp]});
        $display("b2b resp #%0d data=%02h", nresp, resp_data);
        nresp++;
      end
      if (busy > 0) busy--;
      else if (k < 5 && req_ready) begin busy = b_lat[k]; k++; end
      @(negedge clk);
    end
    req_valid = 1'b0;
    check("b2b_ready_busy", ready_bad, 0);
    check("b2b_resp_count", nresp, 5);
    check("b2b_accepted", k, 5);
    check("b2b_writes", bwr, 3);

    // Reset during RDATA of a BSET: no write may escape.
    saw_wr = 1'b0; watch = 1'b1;
    req_valid = 1'b1; req_op = OP_BSET; req_addr = IO_ADDR_LED; req_wdata = 8'h00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_write_en",  {31'd0, io_write_en},  32'd0);
    check("midrst_ready",     {31'd0, req_ready},    32'd0);
    check("midrst_resp_data", {24'd0, resp_data},    32'd0);
    check("midrst_readaddr",  {27'd0, io_readaddr},  32'd0);
    check("midrst_writedata", {24'd0, io_writedata}, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    watch = 1'b0;
    check("midrst_no_write", {31'd0, saw_wr}, 32'd0);
    check("midrst_mem", {24'd0, mem[1]}, 32'h27);
    run_op(OP_READ, IO_ADDR_LED, 8'h00, lat, nwr, wval, waddr, raddr1, rdata);
    check("postrst_resp", {24'd0, rdata}, 32'h27);
    check("postrst_lat", lat, 3);

    // Interrupts
`ifdef IO_IRQ_LATCH_EN
    io_interrupts = 8'h03;
    @(negedge clk);
    io_interrupts = 8'h00;
    #1;
    check("irq_valid_a", {31'd0, irq_valid}, 32'd1);
    check("irq_id_a", {29'd0, irq_id}, 32'd0);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    check("irq_valid_b", {31'd0, irq_valid}, 32'd1);
    check("irq_id_b", {29'd0, irq_id}, 32'd1);
    irq_ack = 1'b1;
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    check("irq_valid_c", {31'd0, irq_valid}, 32'd0);
`else
    io_interrupts = 8'h03;
    #1;
    check("irq_valid_a", {31'd0, irq_valid}, 32'd1);
    check("irq_id_a", {29'd0, irq_id}, 32'd0);
    io_interrupts = 8'hA0;
    #1;
    check("irq_id_a0", {29'd0, irq_id}, 32'd5);
    io_interrupts = 8'h80;
    #1;
    check("irq_id_80", {29'd0, irq_id}, 32'd7);
    @(negedge clk);
    io_interrupts = 8'h00;
    irq_ack = 1'b1;
    #1;
    check("irq_valid_off", {31'd0, irq_valid}, 32'd0);
    @(negedge clk);
    irq_ack = 1'b0;
    #1;
    check("irq_valid_ack", {31'd0, irq_valid}, 32'd0);
`endif
    $display("irq sequence done valid=%0d id=%0d", irq_valid, irq_id);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_bus_master.md
Name: io_bus_master

Overview:
CPU-side initiator for the 5-bit-address / 8-bit-data IO memory bus. It accepts single IO requests from the processor datapath (read, write, bit-set, bit-clear) and sequences them onto the IO bus, which has a registered read address. The responder's read data is therefore valid one cycle after the address is presented. The block also collects the peripheral interrupt lines into a pending flag and a priority vector for the core's interrupt logic.

Parameters:
ADDR_W, 5, IO address width
DATA_W, 8, IO data width
IRQ_W, 8, number of interrupt lines

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
req_valid  input  1  CPU request present
req_ready  output  1  block can accept a request this cycle
req_op  input  2  0=READ, 1=WRITE, 2=BSET, 3=BCLR
req_addr  input  ADDR_W  IO address
req_wdata  input  DATA_W  write data; for BSET/BCLR, bits [2:0] are the bit index
resp_valid  output  1  one-cycle pulse: request complete
resp_data  output  DATA_W  read value; for BSET/BCLR the pre-modify value; for WRITE the written data
io_readaddr  output  ADDR_W  bus read address
io_readdata  input  DATA_W  bus read data, valid one cycle after io_readaddr
io_writeaddr  output  ADDR_W  bus write address
io_writedata  output  DATA_W  bus write data
io_write_en  output  1  bus write strobe
io_interrupts  input  IRQ_W  peripheral interrupt lines
irq_valid  output  1  an interrupt is pending
irq_id  output  3  index of the lowest-numbered pending interrupt
irq_ack  input  1  CPU acknowledges irq_id

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - req_ready = 0 while reset is asserted; req_ready = 1 from the first cycle after release.
  - resp_valid = 0, resp_data = 0.
  - io_readaddr, io_writeaddr, io_writedata = 0; io_write_en = 0.
  - irq_valid = 0, irq_id = 0, and all internal interrupt registers = 0.
- States: IDLE, RADDR, RDATA, WRITE, RESP.
- req_ready = 1 only in IDLE. A handshake is req_valid && req_ready. The block latches op, addr and wdata into op_q, addr_q, wdata_q.
- Transitions:
  - IDLE --READ/BSET/BCLR--> RADDR
  - IDLE --WRITE--> WRITE
  - RADDR --> RDATA
  - RDATA --READ--> RESP
  - RDATA --BSET/BCLR--> WRITE
  - WRITE --> RESP
  - RESP --> IDLE
- io_readaddr = addr_q registered in RADDR and held until the next read.
- In RDATA, io_readdata is captured into resp_data.
  - BSET: modify value = capture | (1 << idx).
  - BCLR: modify value = capture & ~(1 << idx).
- io_write_en = 1 exactly while state == WRITE, with io_writeaddr = addr_q.
  - io_writedata = wdata_q for WRITE, or the modify value for BSET/BCLR.
  - io_writeaddr and io_writedata hold their last values when idle.
- resp_valid = 1 exactly while state == RESP. resp_data holds until the next completion.
- Latency from handshake to resp_valid:
  - READ: 3 cycles.
  - WRITE: 2 cycles.
  - BSET/BCLR: 4 cycles.
- Minimum handshake-to-handshake interval equals latency + 1.
- req_valid while busy is ignored; the CPU must hold the request until ready.
- BSET/BCLR bit index: only bits [2:0] of req_wdata are used; upper bits are ignored.
- Reset mid-operation: everything aborts immediately. No write is issued if reset asserts before WRITE, and io_write_en drops asynchronously.
- Interrupt path, without the optional feature:
  - irq_valid = |io_interrupts.
  - irq_id = index of the lowest-numbered set line.
  - irq_ack is ignored.

Optional Feature:
IO_IRQ_LATCH_EN
- Defined:
  - io_interrupts is registered into irq_prev.
  - pending[i] is set on a rising edge (io_interrupts[i] && !irq_prev[i]).
  - irq_ack clears pending[irq_id].
  - A set and a clear of the same bit in the same cycle: set wins.
  - irq_valid = |pending; irq_id = lowest set index of pending.
- Undefined: level-sensitive pass-through as described under Behaviour.

Decomposition:
- Package io_bus_pkg contains:
  - Op codes: OP_READ, OP_WRITE, OP_BSET, OP_BCLR.
  - State enum.
  - ADDR_W/DATA_W defaults.
  - IO address map constants: IO_ADDR_SWKEY = 0, IO_ADDR_LED = 1, IO_ADDR_TIMER = 2.
- One sub-module, io_irq_latch, holds edge detect, pending register and priority encoder. It contains the IO_IRQ_LATCH_EN conditional.

Test Plan:
- Bench model: a responder with a registered read address; address 1 is an 8-bit register, initial value 0x05.
- READ addr 1 → io_readaddr = 1 for one cycle before capture; resp_valid exactly 3 cycles after handshake; resp_data = 0x05.
- WRITE addr 1, data 0xA3 → io_write_en high for exactly one cycle with io_writeaddr = 1, io_writedata = 0xA3; resp_valid 2 cycles after handshake; subsequent READ returns 0xA3.
- Starting from 0xA3:
  - BSET addr 1, idx 2 → single write of 0xA7; resp_data = 0xA3.
  - Then BCLR idx 7 → write of 0x27; resp_valid 4 cycles after handshake each.
- req_valid held continuously with 5 queued ops → req_ready low during every busy cycle; no op lost or duplicated; exactly 5 resp_valid pulses.
- Reset asserted during RDATA of a BSET → io_write_en never asserts; all outputs reset immediately; first request after release completes normally.
- IO_IRQ_LATCH_EN: pulse lines 1 and 0 for one cycle → irq_valid = 1, irq_id = 0; irq_ack → irq_id = 1; irq_ack → irq_valid = 0. Without the macro, the same stimulus gives irq_valid only during the pulse.
